// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong bank controller for the SPI receive RAM.
// Received bytes fill one bank while the other (if closed) is drained to a
// valid/ready consumer. Banks close on full or on end of frame and are
// drained oldest first. Writes to an occupied bank are dropped and flagged.
module pingpong_buf_ctrl #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    input  logic          frame_end,
    output logic          ram_we,
    output logic [AW:0]   ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_re,
    output logic [AW:0]   ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic          drdy,
    output logic          overrun
);

    typedef enum logic [1:0] {
        B_EMPTY    = 2'd0,
        B_FILLING  = 2'd1,
        B_CLOSED   = 2'd2,
        B_DRAINING = 2'd3
    } bank_st_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_WAIT  = 2'd2
    } rd_st_t;

    localparam logic [AW:0] FULL_C = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE_C  = {{AW{1'b0}}, 1'b1};

    // Bank bookkeeping
    bank_st_t    bank_st_r  [2];
    bank_st_t    bank_nxt_s [2];
    logic [AW:0] len_r      [2];
    logic [AW:0] len_nxt_s  [2];
    logic        drdy_nxt_s;
    logic        drdy_r;

    // Write side
    logic        wr_bank_r;
    logic [AW:0] wr_cnt_r;
    logic        wr_ok_s;
    logic        we_s;
    logic        ovr_s;
    logic [AW:0] wr_cnt_inc_s;
    logic        close_s;

    // Read side
    rd_st_t      rd_st_r;
    rd_st_t      rd_st_nxt_s;
    logic        rd_bank_r;
    logic [AW:0] rd_cnt_r;
    logic        re_s;
    logic        start_drain_s;
    logic        load_s;
    logic        is_last_s;
    logic        hs_s;
    logic        hs_last_s;
    logic [DW-1:0] dout_r;
    logic        dout_valid_r;
    logic        dout_last_r;

    // Write acceptance, write counter advance and bank close decision
    always_comb begin
        wr_ok_s      = (bank_st_r[wr_bank_r] == B_EMPTY) || (bank_st_r[wr_bank_r] == B_FILLING);
        we_s         = wr_valid && wr_ok_s && !rst;
        ovr_s        = wr_valid && !wr_ok_s && !rst;
        wr_cnt_inc_s = wr_cnt_r + {{AW{1'b0}}, we_s};
        close_s      = 1'b0;
        if (we_s && (wr_cnt_inc_s == FULL_C)) begin
            close_s = 1'b1;
        end else if (frame_end && (wr_cnt_inc_s != {(AW+1){1'b0}}) && !rst) begin
            close_s = 1'b1;
        end else begin
            close_s = 1'b0;
        end
    end

    // Read FSM next state and per-cycle read actions
    always_comb begin
        rd_st_nxt_s   = rd_st_r;
        re_s          = 1'b0;
        start_drain_s = 1'b0;
        load_s        = 1'b0;
        is_last_s     = (rd_cnt_r == (len_r[rd_bank_r] - ONE_C));
        hs_s          = dout_valid_r && dout_ready;
        hs_last_s     = hs_s && dout_last_r;
        case (rd_st_r)
            R_IDLE: begin
                if (bank_st_r[rd_bank_r] == B_CLOSED) begin
                    start_drain_s = 1'b1;
                    rd_st_nxt_s   = R_FETCH;
                end else begin
                    rd_st_nxt_s   = R_IDLE;
                end
            end
            R_FETCH: begin
                if (!dout_valid_r || dout_ready) begin
                    re_s        = !rst;
                    rd_st_nxt_s = R_WAIT;
                end else begin
                    rd_st_nxt_s = R_FETCH;
                end
            end
            R_WAIT: begin
                load_s = 1'b1;
                if (is_last_s) begin
                    rd_st_nxt_s = R_IDLE;
                end else begin
                    rd_st_nxt_s = R_FETCH;
                end
            end
            default: begin
                rd_st_nxt_s = R_IDLE;
            end
        endcase
    end

    // Per-bank next state; write and read sides never touch the same bank
    // in the same cycle because they own disjoint state pairs
    always_comb begin
        drdy_nxt_s = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bank_nxt_s[b] = bank_st_r[b];
            len_nxt_s[b]  = len_r[b];
            if (close_s && (wr_bank_r == 1'(b))) begin
                bank_nxt_s[b] = B_CLOSED;
                len_nxt_s[b]  = wr_cnt_inc_s;
            end else if (we_s && (wr_bank_r == 1'(b))) begin
                bank_nxt_s[b] = B_FILLING;
            end else if (start_drain_s && (rd_bank_r == 1'(b))) begin
                bank_nxt_s[b] = B_DRAINING;
            end else if (hs_last_s && (rd_bank_r == 1'(b))) begin
                bank_nxt_s[b] = B_EMPTY;
            end else begin
                bank_nxt_s[b] = bank_st_r[b];
            end
            if ((bank_nxt_s[b] == B_CLOSED) || (bank_nxt_s[b] == B_DRAINING)) begin
                drdy_nxt_s = 1'b1;
            end else begin
                drdy_nxt_s = drdy_nxt_s;
            end
        end
    end

    // Bank state, bank lengths and the registered drdy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_st_r[0] <= B_EMPTY;
            bank_st_r[1] <= B_EMPTY;
            len_r[0]     <= {(AW+1){1'b0}};
            len_r[1]     <= {(AW+1){1'b0}};
            drdy_r       <= 1'b0;
        end else begin
            bank_st_r[0] <= bank_nxt_s[0];
            bank_st_r[1] <= bank_nxt_s[1];
            len_r[0]     <= len_nxt_s[0];
            len_r[1]     <= len_nxt_s[1];
            drdy_r       <= drdy_nxt_s;
        end
    end

    // Write bank pointer and fill counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_r <= 1'b0;
            wr_cnt_r  <= {(AW+1){1'b0}};
        end else if (close_s) begin
            wr_bank_r <= ~wr_bank_r;
            wr_cnt_r  <= {(AW+1){1'b0}};
        end else begin
            wr_cnt_r  <= wr_cnt_inc_s;
        end
    end

    // Read FSM state, read bank pointer and read counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_st_r   <= R_IDLE;
            rd_bank_r <= 1'b0;
            rd_cnt_r  <= {(AW+1){1'b0}};
        end else begin
            rd_st_r <= rd_st_nxt_s;
            if (hs_last_s) begin
                rd_bank_r <= ~rd_bank_r;
                rd_cnt_r  <= {(AW+1){1'b0}};
            end else if (load_s) begin
                rd_cnt_r  <= rd_cnt_r + ONE_C;
            end else begin
                rd_cnt_r  <= rd_cnt_r;
            end
        end
    end

    // Output register: loaded only when empty, so it holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r       <= {DW{1'b0}};
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
        end else if (load_s) begin
            dout_r       <= ram_rdata;
            dout_valid_r <= 1'b1;
            dout_last_r  <= is_last_s;
        end else if (hs_s) begin
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= dout_valid_r;
        end
    end

    assign ram_we     = we_s;
    assign overrun    = ovr_s;
    assign ram_waddr  = we_s ? {wr_bank_r, wr_cnt_r[AW-1:0]} : {(AW+1){1'b0}};
    assign ram_wdata  = we_s ? wr_data : {DW{1'b0}};
    assign ram_re     = re_s;
    assign ram_raddr  = re_s ? {rd_bank_r, rd_cnt_r[AW-1:0]} : {(AW+1){1'b0}};
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign dout_last  = dout_last_r;
    assign drdy       = drdy_r;

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Directed bench for pingpong_buf_ctrl with a 4-deep bank (AW=2).
// Expected output bytes are queued as they are written and checked on
// every output handshake.
module tb_pingpong_buf_ctrl;

    localparam int DW = 8;
    localparam int AW = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } sb_item_t;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          frame_end;
    logic          ram_we;
    logic [AW:0]   ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic          ram_re;
    logic [AW:0]   ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic          drdy;
    logic          overrun;

    logic [7:0] mem [8];
    sb_item_t   q [$];
    sb_item_t   e;
    logic       mbank;
    logic [2:0] mcnt;
    logic       stall_r;
    logic [7:0] hold_d;
    logic       hold_l;
    int         vec_cnt;
    int         err_cnt;

    pingpong_buf_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .frame_end  (frame_end),
        .ram_we     (ram_we),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .ram_re     (ram_re),
        .ram_raddr  (ram_raddr),
        .ram_rdata  (ram_rdata),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .drdy       (drdy),
        .overrun    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        assert (got === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic close_model();
        q[q.size()-1].last = 1'b1;
        mcnt  = 3'd0;
        mbank = ~mbank;
    endtask

    // One write cycle; entered and left at posedge+1
    task automatic wr(input logic [7:0] d, input bit fe, input bit drop);
        wr_valid  = 1'b1;
        wr_data   = d;
        frame_end = fe;
        #2;
        chk("ram_we", ram_we, !drop);
        chk("overrun", overrun, drop);
        if (!drop) begin
            chk("ram_waddr", ram_waddr, {mbank, mcnt[1:0]});
            chk("ram_wdata", ram_wdata, d);
            q.push_back('{data: d, last: 1'b0});
            mcnt = mcnt + 3'd1;
            if (mcnt == 3'd4 || fe) close_model();
        end
        @(posedge clk); #1;
        wr_valid  = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic fend();
        frame_end = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
        if (mcnt != 3'd0) close_model();
    endtask

    task automatic drain_wait(input bit toggle, input int budget);
        int n;
        n = 0;
        while (!(q.size() == 0 && !dout_valid) && n < budget) begin
            @(posedge clk); #1;
            if (toggle) dout_ready = ~dout_ready;
            else        dout_ready = 1'b1;
            n++;
        end
        chk("drain_done", (q.size() == 0 && !dout_valid), 1);
        dout_ready = 1'b1;
        chk("drdy_after_drain", drdy, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_we"},    ram_we, 0);
        chk({tag, "_re"},    ram_re, 0);
        chk({tag, "_waddr"}, ram_waddr, 0);
        chk({tag, "_raddr"}, ram_raddr, 0);
        chk({tag, "_wdata"}, ram_wdata, 0);
        chk({tag, "_dout"},  dout, 0);
        chk({tag, "_dv"},    dout_valid, 0);
        chk({tag, "_last"},  dout_last, 0);
        chk({tag, "_drdy"},  drdy, 0);
        chk({tag, "_ovr"},   overrun, 0);
    endtask

    // Output monitor: scoreboard pop on handshake and hold check while stalled
    always @(negedge clk) begin
        if (rst) begin
            stall_r = 1'b0;
        end else begin
            if (stall_r) begin
                chk("hold_valid", dout_valid, 1);
                chk("hold_dout", dout, hold_d);
                chk("hold_last", dout_last, hold_l);
            end
            if (dout_valid && dout_ready) begin
                chk("sb_nonempty", (q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("dout", dout, e.data);
                    chk("dout_last", dout_last, e.last);
                end
            end
            stall_r = dout_valid && !dout_ready;
            hold_d  = dout;
            hold_l  = dout_last;
        end
    end

    initial begin
        vec_cnt    = 0;
        err_cnt    = 0;
        mbank      = 1'b0;
        mcnt       = 3'd0;
        stall_r    = 1'b0;
        rst        = 1'b1;
        wr_valid   = 1'b0;
        wr_data    = 8'h00;
        frame_end  = 1'b0;
        dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Full-bank fill
        wr(8'h11, 1'b0, 1'b0);
        wr(8'h12, 1'b0, 1'b0);
        wr(8'h13, 1'b0, 1'b0);
        chk("drdy_before_close", drdy, 0);
        wr(8'h14, 1'b0, 1'b0);
        chk("drdy_after_close", drdy, 1);
        drain_wait(1'b0, 40);

        // Short frame closed by frame_end
        wr(8'hA5, 1'b0, 1'b0);
        wr(8'h5A, 1'b0, 1'b0);
        fend();
        chk("drdy_short", drdy, 1);
        drain_wait(1'b0, 40);

        // Frame end together with a byte
        wr(8'h66, 1'b0, 1'b0);
        wr(8'h77, 1'b1, 1'b0);
        drain_wait(1'b0, 40);

        // Overrun: both banks full, ninth byte dropped
        dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(8'h30 + 8'(i), 1'b0, 1'b0);
        wr(8'hEE, 1'b0, 1'b1);
        chk("drdy_both_full", drdy, 1);
        drain_wait(1'b0, 80);

        // Backpressure on a full bank plus a short frame
        for (int i = 0; i < 4; i++) wr(8'h80 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) wr(8'hC0 + 8'(i), 1'b0, 1'b0);
        fend();
        drain_wait(1'b1, 120);

        // Reset while a byte is held at the output
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(8'hD0 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20 && !dout_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("dv_before_rst", dout_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_idle("rst_mid");
        rst = 1'b0;
        q.delete();
        mbank = 1'b0;
        mcnt  = 3'd0;
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) wr(8'hE0 + 8'(i), 1'b0, 1'b0);
        drain_wait(1'b0, 40);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
